// File: rtl/state_duration_checker_if.sv
// Interface bundle for state_duration_checker. It carries the monitored
// line toward the checker and the run reports coming back from it.
interface state_duration_checker_if #(
  parameter int CNT_WIDTH     = 8,
  parameter int ERR_CNT_WIDTH = 16
) ();

  logic                     i_state;
  logic                     o_run_valid;
  logic                     o_run_level;
  logic [CNT_WIDTH-1:0]     o_run_length;
  logic                     o_err_short;
  logic                     o_err_long;
  logic [ERR_CNT_WIDTH-1:0] o_err_count;
  logic                     o_synced;

  // Environment side: drives the monitored line and observes the reports.
  modport master (
    output i_state,
    input  o_run_valid,
    input  o_run_level,
    input  o_run_length,
    input  o_err_short,
    input  o_err_long,
    input  o_err_count,
    input  o_synced
  );

  modport slave (
    input  i_state,
    output o_run_valid,
    output o_run_level,
    output o_run_length,
    output o_err_short,
    output o_err_long,
    output o_err_count,
    output o_synced
  );

endinterface

// File: rtl/state_duration_checker.sv
// Measures low/high run lengths of a one-bit line and reports each
// completed run, too-short and too-long runs, and a saturating error count.
//
// state | meaning
// ARM   | first sample after reset; capture the level, start counting
// SYNC  | partial run in progress; wait for the first edge, no reports
// TRACK | full runs are measured, reported and checked against bounds
module state_duration_checker #(
  parameter int STATE_0_MIN_VALUE = 10,
  parameter int STATE_0_MAX_VALUE = 20,
  parameter int STATE_1_MIN_VALUE = 30,
  parameter int STATE_1_MAX_VALUE = 40,
  parameter int CNT_WIDTH         = 8,
  parameter int ERR_CNT_WIDTH     = 16
) (
  input logic                     i_clk,
  input logic                     i_s_rst,
  state_duration_checker_if.slave mon
);

  if (STATE_0_MIN_VALUE > STATE_0_MAX_VALUE) begin : g_bad_s0_order
    $error("state_duration_checker: STATE_0_MIN_VALUE exceeds STATE_0_MAX_VALUE");
  end
  if (STATE_1_MIN_VALUE > STATE_1_MAX_VALUE) begin : g_bad_s1_order
    $error("state_duration_checker: STATE_1_MIN_VALUE exceeds STATE_1_MAX_VALUE");
  end
  if (STATE_0_MIN_VALUE < 1 || STATE_1_MIN_VALUE < 1) begin : g_bad_min
    $error("state_duration_checker: MIN values must be at least 1");
  end
  // The MAX+1 sample must still be representable below the saturation value.
  if (longint'(STATE_0_MAX_VALUE) >= (longint'(1) << CNT_WIDTH) - 1 ||
      longint'(STATE_1_MAX_VALUE) >= (longint'(1) << CNT_WIDTH) - 1) begin : g_bad_max
    $error("state_duration_checker: MAX values must be below 2^CNT_WIDTH-1");
  end

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_SYNC  = 2'd1,
    ST_TRACK = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0]     LP_CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]     LP_CNT_SAT = '1;
  localparam logic [ERR_CNT_WIDTH-1:0] LP_ERR_SAT = '1;
  localparam logic [CNT_WIDTH-1:0]     LP_S0_MIN  = CNT_WIDTH'(STATE_0_MIN_VALUE);
  localparam logic [CNT_WIDTH-1:0]     LP_S1_MIN  = CNT_WIDTH'(STATE_1_MIN_VALUE);
  localparam logic [CNT_WIDTH-1:0]     LP_S0_LIM  = CNT_WIDTH'(STATE_0_MAX_VALUE + 1);
  localparam logic [CNT_WIDTH-1:0]     LP_S1_LIM  = CNT_WIDTH'(STATE_1_MAX_VALUE + 1);

  state_t                   r_state;
  logic                     r_lvl_q;
  logic [CNT_WIDTH-1:0]     r_cnt;
  logic                     r_long_flag;
  logic                     r_synced;
  logic                     r_run_valid;
  logic                     r_run_level;
  logic [CNT_WIDTH-1:0]     r_run_length;
  logic                     r_err_short;
  logic                     r_err_long;
  logic [ERR_CNT_WIDTH-1:0] r_err_count;

  state_t                   w_nxt_state;
  logic                     w_nxt_lvl_q;
  logic [CNT_WIDTH-1:0]     w_nxt_cnt;
  logic                     w_nxt_long_flag;
  logic                     w_nxt_synced;
  logic                     w_nxt_run_valid;
  logic                     w_nxt_run_level;
  logic [CNT_WIDTH-1:0]     w_nxt_run_length;
  logic                     w_nxt_err_short;
  logic                     w_nxt_err_long;
  logic [ERR_CNT_WIDTH-1:0] w_nxt_err_count;

  logic                     w_edge;
  logic [CNT_WIDTH-1:0]     w_cnt_inc;
  logic [CNT_WIDTH-1:0]     w_min;
  logic [CNT_WIDTH-1:0]     w_lim;
  logic [ERR_CNT_WIDTH-1:0] w_err_inc;

  assign w_edge    = (mon.i_state != r_lvl_q);
  assign w_cnt_inc = (r_cnt == LP_CNT_SAT) ? r_cnt : r_cnt + LP_CNT_ONE;
  assign w_min     = r_lvl_q ? LP_S1_MIN : LP_S0_MIN;
  assign w_lim     = r_lvl_q ? LP_S1_LIM : LP_S0_LIM;
  assign w_err_inc = (r_err_count == LP_ERR_SAT) ? r_err_count
                                                 : r_err_count + ERR_CNT_WIDTH'(1);

  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_lvl_q      = r_lvl_q;
    w_nxt_cnt        = r_cnt;
    w_nxt_long_flag  = r_long_flag;
    w_nxt_synced     = r_synced;
    w_nxt_run_valid  = 1'b0;
    w_nxt_run_level  = r_run_level;
    w_nxt_run_length = r_run_length;
    w_nxt_err_short  = 1'b0;
    w_nxt_err_long   = 1'b0;
    w_nxt_err_count  = r_err_count;

    case (r_state)
      ST_ARM: begin
        w_nxt_lvl_q     = mon.i_state;
        w_nxt_cnt       = LP_CNT_ONE;
        w_nxt_long_flag = 1'b0;
        w_nxt_state     = ST_SYNC;
      end

      ST_SYNC: begin
        if (w_edge) begin
          w_nxt_lvl_q     = mon.i_state;
          w_nxt_cnt       = LP_CNT_ONE;
          w_nxt_long_flag = 1'b0;
          w_nxt_synced    = 1'b1;
          w_nxt_state     = ST_TRACK;
        end else begin
          w_nxt_cnt = w_cnt_inc;
        end
      end

      ST_TRACK: begin
        if (w_edge) begin
          w_nxt_run_valid  = 1'b1;
          w_nxt_run_level  = r_lvl_q;
          w_nxt_run_length = r_cnt;
          if (r_cnt < w_min) begin
            w_nxt_err_short = 1'b1;
            w_nxt_err_count = w_err_inc;
          end
          w_nxt_lvl_q     = mon.i_state;
          w_nxt_cnt       = LP_CNT_ONE;
          w_nxt_long_flag = 1'b0;
        end else begin
          w_nxt_cnt = w_cnt_inc;
          // A too-long run is flagged once, on the sample that crosses MAX.
          if (w_cnt_inc == w_lim && !r_long_flag) begin
            w_nxt_err_long  = 1'b1;
            w_nxt_long_flag = 1'b1;
            w_nxt_err_count = w_err_inc;
          end
        end
      end

      default: begin
        w_nxt_state = ST_ARM;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_s_rst) begin
      r_state      <= ST_ARM;
      r_lvl_q      <= 1'b0;
      r_cnt        <= '0;
      r_long_flag  <= 1'b0;
      r_synced     <= 1'b0;
      r_run_valid  <= 1'b0;
      r_run_level  <= 1'b0;
      r_run_length <= '0;
      r_err_short  <= 1'b0;
      r_err_long   <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_state      <= w_nxt_state;
      r_lvl_q      <= w_nxt_lvl_q;
      r_cnt        <= w_nxt_cnt;
      r_long_flag  <= w_nxt_long_flag;
      r_synced     <= w_nxt_synced;
      r_run_valid  <= w_nxt_run_valid;
      r_run_level  <= w_nxt_run_level;
      r_run_length <= w_nxt_run_length;
      r_err_short  <= w_nxt_err_short;
      r_err_long   <= w_nxt_err_long;
      r_err_count  <= w_nxt_err_count;
    end
  end

  assign mon.o_run_valid  = r_run_valid;
  assign mon.o_run_level  = r_run_level;
  assign mon.o_run_length = r_run_length;
  assign mon.o_err_short  = r_err_short;
  assign mon.o_err_long   = r_err_long;
  assign mon.o_err_count  = r_err_count;
  assign mon.o_synced     = r_synced;

endmodule
